// File: rtl/onehot_enc_pkg.sv
// Shared constants for the one-hot encoder pipeline: mode encodings and default sizing.
package onehot_enc_pkg;

    // Per-word encode mode carried alongside the input vector
    localparam logic MODE_STRICT = 1'b0;   // exactly one bit must be set
    localparam logic MODE_PRIO   = 1'b1;   // highest set bit wins

    // Default sizing for the top level
    localparam int DEF_N     = 16;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/onehot_enc_core.sv
// Combinational encoder: zero detect, single-bit (popcount <= 1) test and
// highest-set-bit search, folded into index / error / zero flags per mode.
module onehot_enc_core
    import onehot_enc_pkg::*;
#(
    parameter  int N = DEF_N,
    localparam int W = $clog2(N)
)
(
    input  logic [N-1:0] i_vec,
    input  logic         i_mode,
    output logic [W-1:0] o_idx,
    output logic         o_err,
    output logic         o_zero
);

    logic         w_any;
    logic         w_single;
    logic [N-1:0] w_vec_m1;
    logic [W-1:0] w_hi;

    // Clearing the lowest set bit leaves zero exactly when at most one bit was set
    assign w_any    = |i_vec;
    assign w_vec_m1 = i_vec - N'(1);
    assign w_single = w_any && ((i_vec & w_vec_m1) == '0);

    // Highest set bit: later (higher) positions overwrite earlier ones
    always_comb begin
        w_hi = '0;
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                w_hi = i[W-1:0];
            end
        end
    end

    // Fold the detectors into the result; in strict mode a lone bit is also the highest bit
    always_comb begin
        o_idx  = '0;
        o_err  = 1'b0;
        o_zero = 1'b0;
        if (!w_any) begin
            o_err  = 1'b1;
            o_zero = 1'b1;
        end else if ((i_mode == MODE_STRICT) && !w_single) begin
            o_err  = 1'b1;
        end else begin
            o_idx  = w_hi;
        end
    end

endmodule

// File: rtl/onehot_encoder_pipe.sv
// Two-stage valid/ready one-hot encoder with a saturating count of delivered errored results.
// S1 registers the raw word and its mode; S2 registers the encoded result.
module onehot_encoder_pipe
    import onehot_enc_pkg::*;
#(
    parameter  int N     = DEF_N,
    parameter  int CNT_W = DEF_CNT_W,
    localparam int W     = $clog2(N)
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_vec,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_idx,
    output logic             out_err,
    output logic             out_zero,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    logic             r_s1_valid;
    logic [N-1:0]     r_s1_vec;
    logic             r_s1_mode;
    logic             r_s2_valid;
    logic [W-1:0]     r_s2_idx;
    logic             r_s2_err;
    logic             r_s2_zero;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_s2_load;
    logic [W-1:0]     w_enc_idx;
    logic             w_enc_err;
    logic             w_enc_zero;

    // Handshake: S2 frees up when empty or draining; S1 accepts when empty or moving into S2.
    // in_ready never looks at in_valid, so no combinational loop through the producer.
    assign w_out_xfer = r_s2_valid && out_ready;
    assign w_s2_load  = !r_s2_valid || w_out_xfer;
    assign in_ready   = !r_s1_valid || w_s2_load;
    assign w_in_xfer  = in_valid && in_ready;

    onehot_enc_core #(.N(N)) u_core (
        .i_vec  (r_s1_vec),
        .i_mode (r_s1_mode),
        .o_idx  (w_enc_idx),
        .o_err  (w_enc_err),
        .o_zero (w_enc_zero)
    );

    // S1: capture the raw word and its mode; a bubble is loaded when S1 drains with no new input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_vec   <= '0;
            r_s1_mode  <= MODE_STRICT;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_in_xfer) begin
                r_s1_vec  <= in_vec;
                r_s1_mode <= in_mode;
            end
        end
    end

    // S2: register the encoded result; held untouched while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_idx   <= '0;
            r_s2_err   <= 1'b0;
            r_s2_zero  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_idx  <= w_enc_idx;
                r_s2_err  <= w_enc_err;
                r_s2_zero <= w_enc_zero;
            end
        end
    end

    // Error counter: counts errored results only when actually delivered; clear beats increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (w_out_xfer && r_s2_err && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_s2_valid;
    assign out_idx   = r_s2_idx;
    assign out_err   = r_s2_err;
    assign out_zero  = r_s2_zero;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Self-checking bench for onehot_encoder_pipe: directed scenarios plus a randomized stream,
// checked against a queue-based reference model. A second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_onehot_encoder_pipe;

    localparam int N = 16;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] idx;
        logic         err;
        logic         zero;
    } res_t;

    typedef struct packed {
        logic       in_ready;
        logic       out_valid;
        logic       out_ready;
        logic       did_in;
        logic       did_out;
        logic       sb_empty;
        logic [7:0] sb_size;
        res_t       obs;
        res_t       exp;
    } smp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_vec;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_idx;
    logic          out_err;
    logic          out_zero;
    logic          err_clr;
    logic [15:0]   err_cnt;

    logic          in_ready_s;
    logic          out_valid_s;
    logic [W-1:0]  out_idx_s;
    logic          out_err_s;
    logic          out_zero_s;
    logic [1:0]    err_cnt_s;

    int   tests = 0;
    int   fails = 0;
    res_t exp_q[$];
    int   cnt_m = 0;
    int   cnt_s = 0;

    always #5 clk = ~clk;

    onehot_encoder_pipe #(.N(N), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_err(out_err), .out_zero(out_zero),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    onehot_encoder_pipe #(.N(N), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_vec(in_vec), .in_mode(in_mode), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_idx(out_idx_s), .out_err(out_err_s), .out_zero(out_zero_s),
        .err_clr(err_clr), .err_cnt(err_cnt_s)
    );

    // Reference: bit count and floor(log2) straight from the encoding rules
    function automatic res_t ref_encode(logic [N-1:0] v, logic m);
        res_t r;
        int   ones;
        ones   = $countones(v);
        r.idx  = '0;
        r.err  = 1'b0;
        r.zero = 1'b0;
        if (ones == 0) begin
            r.err  = 1'b1;
            r.zero = 1'b1;
        end else if (m == 1'b0 && ones != 1) begin
            r.err = 1'b1;
        end else begin
            r.idx = W'($clog2(int'(v) + 1) - 1);
        end
        return r;
    endfunction

    // One clock: sample pre-edge handshake state, update the model, advance past the edge
    task automatic tick(output smp_t s);
        #2;
        s           = '0;
        s.in_ready  = in_ready;
        s.out_valid = out_valid;
        s.out_ready = out_ready;
        s.did_in    = in_valid && in_ready && !rst;
        s.did_out   = out_valid && out_ready && !rst;
        s.obs.idx   = out_idx;
        s.obs.err   = out_err;
        s.obs.zero  = out_zero;
        s.sb_size   = 8'(exp_q.size());
        s.sb_empty  = (exp_q.size() == 0);
        if (s.did_out && !s.sb_empty) s.exp = exp_q.pop_front();
        if (rst) begin
            cnt_m = 0; cnt_s = 0; exp_q.delete();
        end else if (err_clr) begin
            cnt_m = 0; cnt_s = 0;
        end else if (s.did_out && s.exp.err) begin
            if (cnt_m < 65535) cnt_m++;
            if (cnt_s < 3) cnt_s++;
        end
        if (s.did_in) exp_q.push_back(ref_encode(in_vec, in_mode));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        smp_t s;
        rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_mode = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        tick(s);
        tick(s);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        tests++; if (out_idx !== 4'd0) begin fails++; $display("FAIL reset_out_idx: got %0d want 0", out_idx); end
        tests++; if (out_err !== 1'b0 || out_zero !== 1'b0) begin fails++; $display("FAIL reset_flags: got err=%0b zero=%0b want 0 0", out_err, out_zero); end
        tests++; if (err_cnt !== 16'd0 || err_cnt_s !== 2'd0) begin fails++; $display("FAIL reset_err_cnt: got %0d/%0d want 0/0", err_cnt, err_cnt_s); end
        tests++; if (in_ready !== 1'b1 || in_ready_s !== 1'b1) begin fails++; $display("FAIL reset_in_ready_during: got %0b want 1", in_ready); end
        tests++; if (out_valid_s !== 1'b0) begin fails++; $display("FAIL reset_out_valid_s: got %0b want 0", out_valid_s); end
        rst = 1'b0;
        tick(s);
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL reset_after: got in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_strict_stream();
        smp_t       s;
        logic [N-1:0] vecs [4];
        logic [W-1:0] want [4];
        vecs[0] = 16'h0001; vecs[1] = 16'h0020; vecs[2] = 16'h0400; vecs[3] = 16'h8000;
        want[0] = 4'd0;     want[1] = 4'd5;     want[2] = 4'd10;    want[3] = 4'd15;
        out_ready = 1'b1; in_mode = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 4);
            in_vec   = (c < 4) ? vecs[c] : '0;
            tick(s);
            if (s.did_out) begin
                tests++; if (s.sb_empty || s.obs !== s.exp) begin fails++; $display("FAIL stream_model: got idx=%0d err=%0b zero=%0b want idx=%0d err=%0b zero=%0b", s.obs.idx, s.obs.err, s.obs.zero, s.exp.idx, s.exp.err, s.exp.zero); end
            end
            if (c == 0) begin
                tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_latency: got out_valid=%0b after 1 cycle want 0", out_valid); end
            end else if (c <= 4) begin
                tests++; if (out_valid !== 1'b1 || out_idx !== want[c-1] || out_err !== 1'b0) begin fails++; $display("FAIL stream_word%0d: got valid=%0b idx=%0d err=%0b want 1 %0d 0", c-1, out_valid, out_idx, out_err, want[c-1]); end
            end
        end
        in_valid = 1'b0;
        tick(s);
    endtask

    task automatic test_mixed_mode();
        smp_t         s;
        logic [N-1:0] vecs [4];
        logic         mods [4];
        res_t         want [4];
        int           base;
        int           k;
        int           wi;
        vecs[0] = 16'h0028; mods[0] = 1'b0; want[0] = '{idx: 4'd0, err: 1'b1, zero: 1'b0};
        vecs[1] = 16'h0028; mods[1] = 1'b1; want[1] = '{idx: 4'd5, err: 1'b0, zero: 1'b0};
        vecs[2] = 16'h0000; mods[2] = 1'b0; want[2] = '{idx: 4'd0, err: 1'b1, zero: 1'b1};
        vecs[3] = 16'h0000; mods[3] = 1'b1; want[3] = '{idx: 4'd0, err: 1'b1, zero: 1'b1};
        base = int'(err_cnt);
        k = 0; wi = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 12 && k < 4; c++) begin
            in_valid = (wi < 4);
            in_vec   = (wi < 4) ? vecs[wi] : '0;
            in_mode  = (wi < 4) ? mods[wi] : 1'b0;
            tick(s);
            if (s.did_in) wi++;
            if (s.did_out) begin
                tests++; if (s.obs !== want[k]) begin fails++; $display("FAIL mixed_word%0d: got idx=%0d err=%0b zero=%0b want idx=%0d err=%0b zero=%0b", k, s.obs.idx, s.obs.err, s.obs.zero, want[k].idx, want[k].err, want[k].zero); end
                k++;
            end
        end
        in_valid = 1'b0;
        tests++; if (k != 4) begin fails++; $display("FAIL mixed_count: got %0d results want 4", k); end
        tests++; if (int'(err_cnt) != base + 3) begin fails++; $display("FAIL mixed_err_cnt: got %0d want %0d", err_cnt, base + 3); end
    endtask

    task automatic test_stall();
        smp_t s;
        smp_t prev;
        int   wi;
        int   k;
        bit   saw_drop;
        wi = 0; k = 0; saw_drop = 0; prev = '0;
        in_mode = 1'b0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            in_valid  = (wi < 8);
            in_vec    = (wi < 8) ? (16'h0001 << wi) : '0;
            out_ready = !(c >= 3 && c <= 5);
            tick(s);
            if (s.did_in) wi++;
            if (!s.in_ready) saw_drop = 1;
            if (prev.out_valid && !prev.out_ready) begin
                tests++; if (s.out_valid !== 1'b1 || s.obs !== prev.obs) begin fails++; $display("FAIL stall_hold: got valid=%0b idx=%0d want 1 %0d", s.out_valid, s.obs.idx, prev.obs.idx); end
            end
            if (s.did_out) begin
                tests++; if (s.obs.idx !== W'(k) || s.obs.err !== 1'b0) begin fails++; $display("FAIL stall_order: got idx=%0d err=%0b want %0d 0", s.obs.idx, s.obs.err, k); end
                k++;
            end
            prev = s;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tests++; if (k != 8) begin fails++; $display("FAIL stall_count: got %0d results want 8", k); end
        tests++; if (!saw_drop) begin fails++; $display("FAIL stall_in_ready: got no in_ready drop want a drop"); end
    endtask

    task automatic test_saturate();
        smp_t       s;
        logic [1:0] want [5];
        int         wi;
        int         k;
        want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3; want[4] = 2'd3;
        err_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick(s);
        err_clr = 1'b0;
        tests++; if (err_cnt_s !== 2'd0) begin fails++; $display("FAIL sat_clear: got %0d want 0", err_cnt_s); end
        wi = 0; k = 0;
        in_vec = '0; in_mode = 1'b0;
        for (int c = 0; c < 20 && k < 5; c++) begin
            in_valid = (wi < 5);
            tick(s);
            if (s.did_in) wi++;
            if (s.did_out) begin
                tests++; if (err_cnt_s !== want[k]) begin fails++; $display("FAIL sat_step%0d: got %0d want %0d", k, err_cnt_s, want[k]); end
                tests++; if (err_cnt !== 16'(cnt_m)) begin fails++; $display("FAIL sat_main_cnt: got %0d want %0d", err_cnt, cnt_m); end
                k++;
            end
        end
        tests++; if (k != 5) begin fails++; $display("FAIL sat_count: got %0d results want 5", k); end
        // one more errored word, held at the output, then delivered with a concurrent clear
        in_valid = 1'b1; out_ready = 1'b0;
        tick(s);
        in_valid = 1'b0;
        for (int c = 0; c < 5 && !out_valid; c++) tick(s);
        tests++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_idx_s !== 4'd0 || out_zero_s !== 1'b1 || out_err_s !== 1'b1) begin fails++; $display("FAIL sat_pending: got valid=%0b err=%0b want 1 1", out_valid, out_err); end
        err_clr = 1'b1; out_ready = 1'b1;
        tick(s);
        err_clr = 1'b0;
        tests++; if (s.did_out !== 1'b1) begin fails++; $display("FAIL clr_xfer: got %0b want 1", s.did_out); end
        tests++; if (err_cnt_s !== 2'd0 || err_cnt !== 16'd0) begin fails++; $display("FAIL clr_wins: got %0d/%0d want 0/0", err_cnt, err_cnt_s); end
    endtask

    task automatic test_random();
        smp_t s;
        smp_t prev;
        prev = '0;
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_mode   = 1'($urandom_range(0, 1));
            err_clr   = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 3))
                0:       in_vec = '0;
                1:       in_vec = 16'h0001 << $urandom_range(0, 15);
                2:       in_vec = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                default: in_vec = 16'($urandom);
            endcase
            tick(s);
            if (s.did_out) begin
                tests++; if (s.sb_empty || s.obs !== s.exp) begin fails++; $display("FAIL rand_result: got idx=%0d err=%0b zero=%0b want idx=%0d err=%0b zero=%0b", s.obs.idx, s.obs.err, s.obs.zero, s.exp.idx, s.exp.err, s.exp.zero); end
            end
            tests++; if (s.in_ready !== ((s.sb_size < 8'd2) || s.out_ready)) begin fails++; $display("FAIL rand_in_ready: got %0b want %0b (occupancy %0d)", s.in_ready, (s.sb_size < 8'd2) || s.out_ready, s.sb_size); end
            if (prev.out_valid && !prev.out_ready) begin
                tests++; if (s.out_valid !== 1'b1 || s.obs !== prev.obs) begin fails++; $display("FAIL rand_hold: got valid=%0b idx=%0d want 1 %0d", s.out_valid, s.obs.idx, prev.obs.idx); end
            end
            tests++; if (err_cnt !== 16'(cnt_m) || err_cnt_s !== 2'(cnt_s)) begin fails++; $display("FAIL rand_err_cnt: got %0d/%0d want %0d/%0d", err_cnt, err_cnt_s, cnt_m, cnt_s); end
            prev = s;
        end
        in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            tick(s);
            if (s.did_out) begin
                tests++; if (s.sb_empty || s.obs !== s.exp) begin fails++; $display("FAIL rand_drain: got idx=%0d err=%0b want idx=%0d err=%0b", s.obs.idx, s.obs.err, s.exp.idx, s.exp.err); end
            end
        end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL rand_leftover: got %0d undelivered want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        smp_t s;
        bit   stale;
        in_vec = '0; in_mode = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        in_valid = 1'b1;
        tick(s);
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick(s);
        tests++; if (err_cnt === 16'd0) begin fails++; $display("FAIL midrst_pre: got err_cnt 0 want nonzero"); end
        out_ready = 1'b0; in_valid = 1'b1;
        tick(s);
        tick(s);
        in_valid = 1'b0;
        tick(s);
        tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL midrst_full: got valid=%0b in_ready=%0b want 1 0", out_valid, in_ready); end
        rst = 1'b1; out_ready = 1'b1;
        tick(s);
        tests++; if (s.did_out !== 1'b0) begin fails++; $display("FAIL midrst_no_xfer: got %0b want 0", s.did_out); end
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 16'd0) begin fails++; $display("FAIL midrst_state: got valid=%0b in_ready=%0b cnt=%0d want 0 1 0", out_valid, in_ready, err_cnt); end
        rst = 1'b0;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            tick(s);
            if (s.out_valid !== 1'b0) stale = 1;
        end
        tests++; if (stale) begin fails++; $display("FAIL midrst_stale: got a stale word want none"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_strict_stream();
        test_mixed_mode();
        test_stall();
        test_saturate();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
